// File: rtl/msi_bus_arbiter_pkg.sv
// msi_bus_pkg: shared op/state encodings and default widths for the MSI snooping-bus arbiter
package msi_bus_pkg;
  localparam int DEF_N_CORES = 2;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_SNOOP_CYCLES = 1;
  localparam int SRC_W = 3;
  typedef enum logic [1:0] {BUS_RD, BUS_RDX, BUS_UPGR, BUS_FLUSH} bus_op_e;
  typedef enum logic [2:0] {S_IDLE, S_BCAST, S_SNOOP, S_MEM, S_DONE} arb_state_e;
endpackage

// File: rtl/msi_bus_arbiter_if.sv
// msi_bus_arbiter_if: requester, snooper and memory signals of the snooping bus
interface msi_bus_arbiter_if import msi_bus_pkg::*; #(
  parameter int N_CORES = DEF_N_CORES,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic [N_CORES-1:0] req, gnt, done, stall_cpu, snoop_hit, snoop_flush;
  logic [2*N_CORES-1:0] req_op;
  logic [ADDR_W*N_CORES-1:0] req_addr;
  logic [DATA_W*N_CORES-1:0] req_wdata, snoop_data;
  logic bus_valid, mem_req, mem_we, mem_ack, rsp_shared;
  logic [1:0] bus_op;
  logic [ADDR_W-1:0] bus_addr, mem_addr;
  logic [SRC_W-1:0] bus_src;
  logic [DATA_W-1:0] mem_wdata, mem_rdata, rsp_data;
  modport master (
    input req, req_op, req_addr, req_wdata, snoop_hit, snoop_flush, snoop_data, mem_ack, mem_rdata,
    output gnt, done, stall_cpu, bus_valid, bus_op, bus_addr, bus_src,
    output mem_req, mem_we, mem_addr, mem_wdata, rsp_data, rsp_shared
  );
  modport slave (
    output req, req_op, req_addr, req_wdata, snoop_hit, snoop_flush, snoop_data, mem_ack, mem_rdata,
    input gnt, done, stall_cpu, bus_valid, bus_op, bus_addr, bus_src,
    input mem_req, mem_we, mem_addr, mem_wdata, rsp_data, rsp_shared
  );
endinterface

// File: rtl/msi_bus_arbiter_rr_arbiter.sv
// rr_arbiter: first requester at or after the pointer, wrapping, as one-hot plus index
module rr_arbiter import msi_bus_pkg::*; #(
  parameter int N = DEF_N_CORES
) (
  input  logic [N-1:0]     i_req,
  input  logic [SRC_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [SRC_W-1:0] o_idx,
  output logic             o_any
);
  always_comb begin
    o_any = |i_req;
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (i_req[(int'(i_ptr) + k) % N]) o_idx = SRC_W'((int'(i_ptr) + k) % N);
    o_gnt = o_any ? N'(1) << o_idx : '0;
  end
endmodule

// File: rtl/msi_bus_arbiter.sv
// msi_bus_arbiter: round-robin snooping-bus controller with snoop collection and a single memory port
module msi_bus_arbiter import msi_bus_pkg::*; #(
  parameter int N_CORES = DEF_N_CORES,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SNOOP_CYCLES = DEF_SNOOP_CYCLES
) (
  input logic clk,
  input logic reset,
  msi_bus_arbiter_if.master bus
);
  localparam int CW = $clog2(SNOOP_CYCLES + 1);
  arb_state_e r_state;
  bus_op_e r_op, w_op;
  logic [SRC_W-1:0] r_idx, r_ptr, w_idx, w_fidx;
  logic [N_CORES-1:0] r_gnt, r_done, w_gnt, w_hit, w_flush;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_rsp_data, w_fdata;
  logic [CW-1:0] r_cnt;
  logic r_bus_valid, r_mem_req, r_mem_we, r_shared, r_rsp_shared, w_any, w_fany;
  rr_arbiter #(.N(N_CORES)) u_rr (
    .i_req(bus.req), .i_ptr(r_ptr), .o_gnt(w_gnt), .o_idx(w_idx), .o_any(w_any)
  );
  assign w_op = bus_op_e'(bus.req_op[int'(w_idx)*2 +: 2]);
  // the granted core never snoops its own transaction
  assign w_hit = bus.snoop_hit & ~r_gnt;
  assign w_flush = bus.snoop_flush & ~r_gnt;
  always_comb begin
    w_fany = 1'b0;
    w_fidx = '0;
    for (int i = N_CORES - 1; i >= 0; i--)
      if (w_flush[i]) begin
        w_fany = 1'b1;
        w_fidx = SRC_W'(i);
      end
  end
  assign w_fdata = bus.snoop_data[int'(w_fidx)*DATA_W +: DATA_W];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= S_IDLE;
      r_op <= BUS_RD;
      r_idx <= '0;
      r_ptr <= '0;
      r_gnt <= '0;
      r_done <= '0;
      r_addr <= '0;
      r_mem_wdata <= '0;
      r_rsp_data <= '0;
      r_cnt <= '0;
      r_bus_valid <= 1'b0;
      r_mem_req <= 1'b0;
      r_mem_we <= 1'b0;
      r_shared <= 1'b0;
      r_rsp_shared <= 1'b0;
    end else begin
      r_done <= '0;
      r_bus_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (w_any) begin
          r_idx <= w_idx;
          r_gnt <= w_gnt;
          r_op <= w_op;
          r_addr <= bus.req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
          r_mem_wdata <= bus.req_wdata[int'(w_idx)*DATA_W +: DATA_W];
          r_shared <= 1'b0;
          r_cnt <= '0;
          r_mem_req <= w_op == BUS_FLUSH;
          r_mem_we <= w_op == BUS_FLUSH;
          r_bus_valid <= w_op != BUS_FLUSH;
          r_state <= w_op == BUS_FLUSH ? S_MEM : S_BCAST;
        end
        S_BCAST: r_state <= S_SNOOP;
        // SNOOP lasts SNOOP_CYCLES wait cycles plus the sampling cycle
        S_SNOOP: if (r_cnt == CW'(SNOOP_CYCLES)) begin
          r_shared <= |w_hit;
          if (r_op == BUS_UPGR) begin
            r_rsp_shared <= |w_hit;
            r_done <= r_gnt;
            r_state <= S_DONE;
          end else begin
            r_mem_req <= 1'b1;
            r_mem_we <= w_fany;
            if (w_fany) r_mem_wdata <= w_fdata;
            r_state <= S_MEM;
          end
        end else r_cnt <= r_cnt + 1'b1;
        S_MEM: if (bus.mem_ack) begin
          r_mem_req <= 1'b0;
          r_rsp_data <= r_mem_we ? r_mem_wdata : bus.mem_rdata;
          r_rsp_shared <= r_shared;
          r_done <= r_gnt;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_gnt <= '0;
          r_ptr <= int'(r_idx) == N_CORES - 1 ? '0 : r_idx + 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  assign bus.gnt = r_gnt;
  assign bus.done = r_done;
  assign bus.stall_cpu = bus.req & ~r_done;
  assign bus.bus_valid = r_bus_valid;
  assign bus.bus_op = r_op;
  assign bus.bus_addr = r_addr;
  assign bus.bus_src = r_idx;
  assign bus.mem_req = r_mem_req;
  assign bus.mem_we = r_mem_we;
  assign bus.mem_addr = r_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.rsp_data = r_rsp_data;
  assign bus.rsp_shared = r_rsp_shared;
endmodule

// File: tb/tb_msi_bus_arbiter.sv
// tb_msi_bus_arbiter: scoreboard bench with a latency-programmable memory responder
module tb_msi_bus_arbiter;
  import msi_bus_pkg::*;
  localparam int N = 2, AW = 9, DW = 32, SC = 1;
  typedef struct {logic [N-1:0] done; logic [DW-1:0] data; logic shared;} rsp_t;
  typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} mem_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  msi_bus_arbiter_if #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus();
  msi_bus_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .SNOOP_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  rsp_t exp_q[$];
  mem_t exp_m[$], obs_m[$];
  int n_cmp = 0, n_fail = 0;
  int mem_lat = 0, mcnt = 0, bv_cnt = 0, mreq_cyc = 0, ovl = 0;
  logic [DW-1:0] mem_val = '0;
  logic [AW-1:0] last_addr = '0;
  logic [2:0] last_src = '0;
  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if ($countones(bus.gnt) > 1) ovl++;
      if (bus.bus_valid === 1'b1) begin
        bv_cnt++;
        last_addr = bus.bus_addr;
        last_src = bus.bus_src;
      end
      if (reset) begin
        bus.mem_ack = 1'b0;
        mcnt = 0;
      end else if (bus.mem_ack) bus.mem_ack = 1'b0;
      else if (bus.mem_req === 1'b1) begin
        mreq_cyc++;
        if (mcnt >= mem_lat) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = mem_val;
          obs_m.push_back('{bus.mem_we, bus.mem_addr, bus.mem_wdata});
          mcnt = 0;
        end else mcnt++;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic clear_inputs();
    bus.req = '0;
    bus.req_op = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.snoop_hit = '0;
    bus.snoop_flush = '0;
    bus.snoop_data = '0;
  endtask
  task automatic drive(input int c, input bus_op_e op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_op[2*c +: 2] = op;
    bus.req_addr[AW*c +: AW] = a;
    bus.req_wdata[DW*c +: DW] = d;
    bus.req[c] = 1'b1;
  endtask
  task automatic wait_done(input int lim, output logic [N-1:0] dv, output int cyc);
    dv = '0;
    cyc = 0;
    while (cyc < lim && dv == '0) begin
      @(negedge clk);
      cyc++;
      dv = bus.done;
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.gnt !== '0) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", bus.gnt); end
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
    n_cmp++; if (bus.bus_valid !== 1'b0) begin n_fail++; $display("FAIL reset_bus_valid: got %b expected 0", bus.bus_valid); end
    n_cmp++; if (bus.rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data: got %h expected 0", bus.rsp_data); end
    reset = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_single_read();
    logic [N-1:0] dv;
    int cyc, bv0;
    rsp_t e;
    mem_t m, o;
    bv0 = bv_cnt;
    mem_lat = 2;
    mem_val = 32'hDEADBEEF;
    exp_q.push_back('{2'b01, 32'hDEADBEEF, 1'b0});
    exp_m.push_back('{1'b0, 9'h01A, '0});
    drive(0, BUS_RD, 9'h01A, '0);
    wait_done(40, dv, cyc);
    clear_inputs();
    e = exp_q.pop_front();
    m = exp_m.pop_front();
    n_cmp++; if (dv !== e.done) begin n_fail++; $display("FAIL rd_done: got %b expected %b", dv, e.done); end
    n_cmp++; if (bus.rsp_data !== e.data) begin n_fail++; $display("FAIL rd_data: got %h expected %h", bus.rsp_data, e.data); end
    n_cmp++; if (bus.rsp_shared !== e.shared) begin n_fail++; $display("FAIL rd_shared: got %b expected %b", bus.rsp_shared, e.shared); end
    n_cmp++; if (bv_cnt - bv0 !== 1) begin n_fail++; $display("FAIL rd_bus_valid_count: got %0d expected 1", bv_cnt - bv0); end
    n_cmp++; if (last_addr !== 9'h01A || last_src !== 3'd0) begin n_fail++; $display("FAIL rd_bcast: got %h/%0d expected 01a/0", last_addr, last_src); end
    n_cmp++;
    if (obs_m.size() == 0) begin n_fail++; $display("FAIL rd_mem: got no access expected read %h", m.addr); end
    else begin
      o = obs_m.pop_front();
      if (o.we !== m.we || o.addr !== m.addr) begin n_fail++; $display("FAIL rd_mem: got we=%b addr=%h expected we=%b addr=%h", o.we, o.addr, m.we, m.addr); end
    end
    @(negedge clk);
  endtask
  task automatic test_rdx_flush();
    logic [N-1:0] dv;
    int cyc;
    rsp_t e;
    mem_t m, o;
    mem_lat = 1;
    mem_val = 32'h0BAD0BAD;
    exp_q.push_back('{2'b10, 32'h12345678, 1'b1});
    exp_m.push_back('{1'b1, 9'h005, 32'h12345678});
    bus.snoop_hit = 2'b01;
    bus.snoop_flush = 2'b01;
    bus.snoop_data = {32'hFFFF0000, 32'h12345678};
    drive(1, BUS_RDX, 9'h005, '0);
    wait_done(40, dv, cyc);
    clear_inputs();
    e = exp_q.pop_front();
    m = exp_m.pop_front();
    n_cmp++; if (dv !== e.done) begin n_fail++; $display("FAIL rdx_done: got %b expected %b", dv, e.done); end
    n_cmp++; if (bus.rsp_data !== e.data) begin n_fail++; $display("FAIL rdx_data: got %h expected %h", bus.rsp_data, e.data); end
    n_cmp++; if (bus.rsp_shared !== e.shared) begin n_fail++; $display("FAIL rdx_shared: got %b expected %b", bus.rsp_shared, e.shared); end
    n_cmp++;
    if (obs_m.size() == 0) begin n_fail++; $display("FAIL rdx_mem: got no access expected write %h", m.addr); end
    else begin
      o = obs_m.pop_front();
      if (o !== m) begin n_fail++; $display("FAIL rdx_mem: got we=%b %h/%h expected we=%b %h/%h", o.we, o.addr, o.wdata, m.we, m.addr, m.wdata); end
    end
    @(negedge clk);
  endtask
  task automatic test_round_robin();
    logic [N-1:0] dv;
    int cyc;
    rsp_t e;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mem_lat = 0;
    ovl = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back('{(i % 2 == 0) ? 2'b01 : 2'b10, '0, 1'b0});
    drive(0, BUS_RD, 9'h010, '0);
    drive(1, BUS_RD, 9'h020, '0);
    for (int i = 0; i < 4; i++) begin
      wait_done(40, dv, cyc);
      e = exp_q.pop_front();
      n_cmp++; if (dv !== e.done) begin n_fail++; $display("FAIL rr_done%0d: got %b expected %b", i, dv, e.done); end
      n_cmp++; if (bus.stall_cpu !== (2'b11 & ~e.done)) begin n_fail++; $display("FAIL rr_stall%0d: got %b expected %b", i, bus.stall_cpu, 2'b11 & ~e.done); end
    end
    clear_inputs();
    n_cmp++; if (ovl !== 0) begin n_fail++; $display("FAIL rr_gnt_overlap: got %0d cycles expected 0", ovl); end
    obs_m.delete();
    @(negedge clk);
  endtask
  task automatic test_upgrade();
    logic [N-1:0] dv;
    int cyc, g, mr0;
    rsp_t e;
    mr0 = mreq_cyc;
    g = 0;
    exp_q.push_back('{2'b01, '0, 1'b1});
    bus.snoop_hit = 2'b10;
    drive(0, BUS_UPGR, 9'h033, '0);
    while (g < 10 && bus.gnt[0] !== 1'b1) begin @(negedge clk); g++; end
    n_cmp++; if (bus.gnt !== 2'b01) begin n_fail++; $display("FAIL upgr_gnt: got %b expected 01", bus.gnt); end
    wait_done(20, dv, cyc);
    clear_inputs();
    e = exp_q.pop_front();
    n_cmp++; if (dv !== e.done) begin n_fail++; $display("FAIL upgr_done: got %b expected %b", dv, e.done); end
    n_cmp++; if (cyc !== 2 + SC) begin n_fail++; $display("FAIL upgr_latency: got %0d expected %0d", cyc, 2 + SC); end
    n_cmp++; if (bus.rsp_shared !== e.shared) begin n_fail++; $display("FAIL upgr_shared: got %b expected %b", bus.rsp_shared, e.shared); end
    n_cmp++; if (mreq_cyc !== mr0) begin n_fail++; $display("FAIL upgr_no_mem: got %0d mem cycles expected 0", mreq_cyc - mr0); end
    @(negedge clk);
  endtask
  task automatic test_flush_op();
    logic [N-1:0] dv;
    int cyc, bv0;
    rsp_t e;
    mem_t m, o;
    bv0 = bv_cnt;
    mem_lat = 1;
    exp_q.push_back('{2'b10, 32'hA5A5A5A5, 1'b0});
    exp_m.push_back('{1'b1, 9'h1FF, 32'hA5A5A5A5});
    drive(1, BUS_FLUSH, 9'h1FF, 32'hA5A5A5A5);
    wait_done(40, dv, cyc);
    clear_inputs();
    e = exp_q.pop_front();
    m = exp_m.pop_front();
    n_cmp++; if (dv !== e.done) begin n_fail++; $display("FAIL flush_done: got %b expected %b", dv, e.done); end
    n_cmp++; if (bv_cnt !== bv0) begin n_fail++; $display("FAIL flush_no_bcast: got %0d strobes expected 0", bv_cnt - bv0); end
    n_cmp++;
    if (obs_m.size() == 0) begin n_fail++; $display("FAIL flush_mem: got no access expected write %h", m.addr); end
    else begin
      o = obs_m.pop_front();
      if (o !== m) begin n_fail++; $display("FAIL flush_mem: got we=%b %h/%h expected we=%b %h/%h", o.we, o.addr, o.wdata, m.we, m.addr, m.wdata); end
    end
    @(negedge clk);
  endtask
  task automatic test_own_mask();
    logic [N-1:0] dv;
    int cyc;
    rsp_t e;
    mem_t m, o;
    mem_lat = 0;
    mem_val = 32'h00C0FFEE;
    exp_q.push_back('{2'b01, 32'h00C0FFEE, 1'b0});
    exp_m.push_back('{1'b0, 9'h077, '0});
    bus.snoop_hit = 2'b01;
    bus.snoop_flush = 2'b01;
    bus.snoop_data = {32'h0, 32'hBADBAD00};
    drive(0, BUS_RD, 9'h077, '0);
    wait_done(40, dv, cyc);
    clear_inputs();
    e = exp_q.pop_front();
    m = exp_m.pop_front();
    n_cmp++; if (dv !== e.done) begin n_fail++; $display("FAIL mask_done: got %b expected %b", dv, e.done); end
    n_cmp++; if (bus.rsp_data !== e.data) begin n_fail++; $display("FAIL mask_data: got %h expected %h", bus.rsp_data, e.data); end
    n_cmp++; if (bus.rsp_shared !== e.shared) begin n_fail++; $display("FAIL mask_shared: got %b expected %b", bus.rsp_shared, e.shared); end
    n_cmp++;
    if (obs_m.size() == 0) begin n_fail++; $display("FAIL mask_mem: got no access expected read %h", m.addr); end
    else begin
      o = obs_m.pop_front();
      if (o.we !== m.we || o.addr !== m.addr) begin n_fail++; $display("FAIL mask_mem: got we=%b addr=%h expected we=%b addr=%h", o.we, o.addr, m.we, m.addr); end
    end
    @(negedge clk);
  endtask
  task automatic test_reset_in_mem();
    logic [N-1:0] dv;
    int cyc, w;
    rsp_t e;
    mem_lat = 50;
    w = 0;
    drive(1, BUS_RD, 9'h100, '0);
    while (w < 20 && bus.mem_req !== 1'b1) begin @(negedge clk); w++; end
    n_cmp++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mem_reach: got mem_req=%b expected 1", bus.mem_req); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b expected 0", bus.mem_req); end
    n_cmp++; if (bus.gnt !== '0) begin n_fail++; $display("FAIL rst_gnt: got %b expected 00", bus.gnt); end
    n_cmp++; if (bus.done !== '0) begin n_fail++; $display("FAIL rst_done: got %b expected 00", bus.done); end
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mem_lat = 0;
    obs_m.delete();
    exp_q.push_back('{2'b01, '0, 1'b0});
    drive(0, BUS_RD, 9'h0AA, '0);
    drive(1, BUS_RD, 9'h0BB, '0);
    wait_done(40, dv, cyc);
    clear_inputs();
    e = exp_q.pop_front();
    n_cmp++; if (dv !== e.done) begin n_fail++; $display("FAIL rst_first_grant: got %b expected %b", dv, e.done); end
    obs_m.delete();
    repeat (2) @(negedge clk);
  endtask
  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_rdx_flush();
    test_round_robin();
    test_upgrade();
    test_flush_op();
    test_own_mask();
    test_reset_in_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/msi_bus_arbiter.md
Name: msi_bus_arbiter

Overview:
Shared snooping-bus controller for the MSI coherence fabric. Takes bus transactions (BusRd, BusRdX, BusUpgr, Flush) from N core/cache requesters, grants the bus round-robin, broadcasts each transaction to all snoopers and collects their responses. It then drives the single main-memory port and returns data plus a per-core stall/done handshake, so cores stall (stall_cpu) until their transaction retires.

Parameters:
N_CORES, 2, number of requesters/snoopers (2..8)
ADDR_W, 9, address width, matches the core address bus
DATA_W, 32, data word width
SNOOP_CYCLES, 1, cycles after broadcast before snoop responses are sampled (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  N_CORES  per-core request; held until done
req_op  in  2*N_CORES  per-core op: 0 BusRd, 1 BusRdX, 2 BusUpgr, 3 Flush
req_addr  in  ADDR_W*N_CORES  per-core address
req_wdata  in  DATA_W*N_CORES  per-core Flush data
gnt  out  N_CORES  one-hot grant, held for whole transaction
done  out  N_CORES  one-cycle retire pulse to granted core
stall_cpu  out  N_CORES  req[i] & ~done[i]
bus_valid  out  1  one-cycle broadcast strobe
bus_op  out  2  broadcast op
bus_addr  out  ADDR_W  broadcast address
bus_src  out  3  granted core index
snoop_hit  in  N_CORES  snooper i holds line (S or M)
snoop_flush  in  N_CORES  snooper i holds line in M and supplies data
snoop_data  in  DATA_W*N_CORES  flush data per snooper
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 write, 0 read
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory completion (1 cycle)
mem_rdata  in  DATA_W  read data, valid with mem_ack
rsp_data  out  DATA_W  returned data, valid with done
rsp_shared  out  1  another core had the line (valid with done)

Behaviour:
- Reset: state IDLE, rr pointer 0, all outputs 0; in-flight transaction abandoned, mem_req drops immediately.
- States: IDLE, BCAST, SNOOP, MEM, DONE.
- IDLE: if any req, pick first requesting index at/after rr pointer (wrap modulo N_CORES); latch op/addr/wdata/index; gnt asserts next cycle -> BCAST. Flush skips snooping -> MEM.
- BCAST: bus_valid=1 for exactly one cycle with latched op/addr/src -> SNOOP.
- SNOOP: wait SNOOP_CYCLES, then sample snoop_hit/flush/data, granted core's own bits masked. rsp_shared = OR of masked hits.
  - BusUpgr: no memory access -> DONE.
  - BusRd/BusRdX with a masked flush: lowest-index flushing snooper supplies rsp_data; memory write-back of that data (mem_we=1) -> MEM.
  - Otherwise: memory read -> MEM.
- MEM: mem_req held with stable addr/we/wdata until mem_ack; read data captured into rsp_data on ack (write-back path keeps snooper data) -> DONE. No timeout.
- DONE: done[idx]=1 one cycle, gnt deasserts same cycle end; rr pointer = idx+1 mod N_CORES -> IDLE. Min latency grant-to-done: BusUpgr 2+SNOOP_CYCLES; memory ops 3+SNOOP_CYCLES+mem latency.
- Exactly one transaction in flight; new grant never in the same cycle as done.
- req dropped mid-transaction: transaction still completes, done still pulses.
- Multiple flush bits asserted: protocol error, lowest index wins, no other effect.
- rsp_data/rsp_shared hold value until next DONE.

Decomposition:
- Package msi_bus_pkg: bus_op_e enum (BUS_RD, BUS_RDX, BUS_UPGR, BUS_FLUSH), arb_state_e, default widths.
- Sub-module rr_arbiter (request vector + pointer -> one-hot grant, index); everything else in top.

Test Plan:
- Single BusRd core0 addr 9'h01A, no snoop hits, mem_ack after 2 cycles with 32'hDEADBEEF -> one bus_valid, mem read 9'h01A, done[0] with rsp_data DEADBEEF, rsp_shared=0.
- Core1 BusRdX addr 9'h005, core0 snoop_flush with 32'h12345678 -> mem write 9'h005/12345678, done[1] rsp_data 12345678, rsp_shared=1.
- Both cores requesting continuously from reset -> grants alternate 0,1,0,1; no gnt overlap; stall_cpu high on the waiting core.
- Core0 BusUpgr, core1 snoop_hit=1 -> no mem_req, done[0] exactly 2+SNOOP_CYCLES cycles after gnt, rsp_shared=1.
- Core1 Flush addr 9'h1FF data 32'hA5A5A5A5 -> no bus_valid, mem write 9'h1FF/A5A5A5A5, done[1].
- reset asserted while in MEM -> mem_req, gnt, done low immediately; next req starts at core0.
